// File: rtl/noc_pkg.sv
// Shared definitions for the ring NoC traffic sources: packet layout,
// traffic pattern codes, source FSM states and a packet builder.
package noc_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = 48;
  localparam int TS_HI     = 47;
  localparam int TS_LO     = 32;
  localparam int SRC_HI    = 31;
  localparam int SRC_LO    = 16;
  localparam int DST_HI    = 15;
  localparam int DST_LO    = 0;

  localparam int PATTERN_BIT_COMPLEMENT = 0;
  localparam int PATTERN_NEXT_NEIGHBOUR = 1;
  localparam int PATTERN_UNIFORM_RANDOM = 2;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    STALL,
    DRAIN,
    DONE
  } inj_state_e;

  function automatic logic [PKT_W-1:0] build_packet(
    input logic [15:0] ts,
    input logic [15:0] src,
    input logic [15:0] dst
  );
    logic [PKT_W-1:0] pkt;
    pkt                = '0;
    pkt[VALID_BIT]     = 1'b1;
    pkt[TS_HI:TS_LO]   = ts;
    pkt[SRC_HI:SRC_LO] = src;
    pkt[DST_HI:DST_LO] = dst;
    return pkt;
  endfunction

endpackage

// File: rtl/inject_fifo.sv
// Small synchronous FIFO between the packet generator and the router.
// Pointers carry one extra bit so full and empty can be told apart.
module inject_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop = pop && !empty;
  // A same-cycle pop frees the head slot, so a push is still legal when full
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/injection_source.sv
// Per-node packet generator for the ring NoC: paces generation attempts,
// picks destinations by traffic pattern, queues packets and feeds the router.
module injection_source
  import noc_pkg::*;
#(
  parameter int          NUM_NODES            = 4,
  parameter int          ROUTER_ID            = 0,
  parameter int          PACKET_SIZE          = 49,
  parameter int          QUEUE_DEPTH          = 4,
  parameter int          INJECT_CYCLE         = 2,
  parameter int          NUM_PACKETS_PER_NODE = 20,
  parameter int          TRAFFIC_PATTERN      = 0,
  parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            clk_counter,
  input  logic                   enable,
  output logic [PACKET_SIZE-1:0] pkt_out,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [63:0]            total_packet_generated,
  output logic [63:0]            total_packet_sent,
  output logic [63:0]            gen_stall_cycles,
  output logic                   done
);

  localparam int          TICK_W    = (INJECT_CYCLE > 1) ? $clog2(INJECT_CYCLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(INJECT_CYCLE - 1);
  localparam logic [15:0] NODE_MASK = 16'(NUM_NODES - 1);
  localparam logic [15:0] MY_ID     = 16'(ROUTER_ID);
  localparam logic [63:0] GEN_LIMIT = 64'(NUM_PACKETS_PER_NODE);

  inj_state_e             state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [PACKET_SIZE-1:0] pending_q, pending_d;
  logic [63:0]            gen_q, gen_d;
  logic [63:0]            sent_q, sent_d;
  logic [63:0]            stall_q, stall_d;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PACKET_SIZE-1:0] fifo_head;
  logic                   fifo_push;
  logic [PACKET_SIZE-1:0] fifo_push_data;
  logic                   pop;
  logic [15:0]            dst;
  logic [15:0]            rand_dst;
  logic [15:0]            lfsr_next;
  logic [PACKET_SIZE-1:0] new_pkt;

  assign pkt_valid = !fifo_empty;
  assign pop       = pkt_valid && pkt_ready;
  assign pkt_out   = fifo_empty ? '0 : fifo_head;
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Random destinations never target this node; a self hit moves to the neighbour
  always_comb begin
    rand_dst = lfsr_q & NODE_MASK;
    if (rand_dst == MY_ID) rand_dst = (rand_dst + 16'd1) & NODE_MASK;
    if (TRAFFIC_PATTERN == PATTERN_BIT_COMPLEMENT)      dst = (~MY_ID) & NODE_MASK;
    else if (TRAFFIC_PATTERN == PATTERN_NEXT_NEIGHBOUR) dst = (MY_ID + 16'd1) & NODE_MASK;
    else                                                dst = rand_dst;
  end

  assign new_pkt = PACKET_SIZE'(build_packet(clk_counter, MY_ID, dst));

  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    lfsr_d         = lfsr_q;
    pending_d      = pending_q;
    gen_d          = gen_q;
    stall_d        = stall_q;
    sent_d         = pop ? sent_q + 64'd1 : sent_q;
    fifo_push      = 1'b0;
    fifo_push_data = new_pkt;
    unique case (state_q)
      IDLE: if (enable) state_d = GEN;
      GEN: begin
        if (gen_q == GEN_LIMIT) begin
          state_d = DRAIN;
        end else if (!enable) begin
          state_d = IDLE;
        end else begin
          tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
          // Generation counts every created packet, including one left pending
          if (tick_q == TICK_LAST) begin
            gen_d  = gen_q + 64'd1;
            lfsr_d = lfsr_next;
            if (!fifo_full || pop) begin
              fifo_push = 1'b1;
            end else begin
              pending_d = new_pkt;
              state_d   = STALL;
            end
          end
        end
      end
      STALL: begin
        stall_d        = stall_q + 64'd1;
        fifo_push_data = pending_q;
        if (!fifo_full || pop) begin
          fifo_push = 1'b1;
          state_d   = GEN;
        end
      end
      DRAIN: if (fifo_empty) state_d = DONE;
      DONE:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      pending_q <= '0;
      gen_q     <= '0;
      sent_q    <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      lfsr_q    <= lfsr_d;
      pending_q <= pending_d;
      gen_q     <= gen_d;
      sent_q    <= sent_d;
      stall_q   <= stall_d;
    end
  end

  inject_fifo #(
    .WIDTH (PACKET_SIZE),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign total_packet_generated = gen_q;
  assign total_packet_sent      = sent_q;
  assign gen_stall_cycles       = stall_q;
  assign done                   = (state_q == DONE);

endmodule
